branch_ctrl_unit: RTL and testbench

- Parametrised successor to the single-cycle branch resolver.
- Owns the architectural program counter register, a registered N/Z/C flag file and a link register.
- Optionally owns a small return-address stack (RAS).
- Sits between decode and instruction fetch. Each accepted instruction resolves the next PC, and the PC register updates on the following clock edge.

---
 rtl/branch_ctrl_pkg.sv | 25 ++
 rtl/branch_ras.sv | 50 +++++
 rtl/branch_ctrl_unit.sv | 116 +++++++++++
 tb/tb_branch_ctrl_unit.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/branch_ctrl_pkg.sv
// rtl/branch_ctrl_pkg.sv - branch class/function encodings and flag record shared by the branch unit
package branch_ctrl_pkg;

  localparam logic [1:0] BR_NONE  = 2'b00;
  localparam logic [1:0] BR_REG   = 2'b01;
  localparam logic [1:0] BR_CARRY = 2'b10;
  localparam logic [1:0] BR_LINK  = 2'b11;

  // Codes are only unique within their class
  localparam logic [5:0] FN_BR   = 6'd0;
  localparam logic [5:0] FN_BLTZ = 6'd1;
  localparam logic [5:0] FN_BZ   = 6'd2;
  localparam logic [5:0] FN_BNZ  = 6'd3;
  localparam logic [5:0] FN_RET  = 6'd4;
  localparam logic [5:0] FN_B    = 6'd0;
  localparam logic [5:0] FN_BCY  = 6'd1;
  localparam logic [5:0] FN_BNCY = 6'd2;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
  } flags_t;

endpackage

// File: rtl/branch_ras.sv
// rtl/branch_ras.sv - circular return-address stack, used only when BRANCH_CTRL_RAS_EN is defined
module branch_ras #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top_data,
  output logic             empty,
  output logic             underflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    ptr;
  logic [CW-1:0]    count;
  logic [PW-1:0]    top_idx;

  // ptr names the next free slot; when full that slot holds the oldest entry
  assign top_idx  = ptr - PW'(1);
  assign top_data = mem[top_idx];
  assign empty    = (count == '0);

  always_ff @(posedge clk) begin
    if (push) mem[ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= '0;
      count     <= '0;
      underflow <= 1'b0;
    end else begin
      underflow <= pop & empty;
      if (push) begin
        ptr <= ptr + PW'(1);
        if (count != CW'(DEPTH)) count <= count + CW'(1);
      end else if (pop && !empty) begin
        ptr   <= top_idx;
        count <= count - CW'(1);
      end
    end
  end

endmodule

// File: rtl/branch_ctrl_unit.sv
// rtl/branch_ctrl_unit.sv - PC/flag/link owner resolving next PC; BRANCH_CTRL_RAS_EN adds a return stack
module branch_ctrl_unit
  import branch_ctrl_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_PC  = '0,
  parameter int               RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  input  logic             stall,
  input  logic [1:0]       branch,
  input  logic [5:0]       function_code,
  input  logic [WIDTH-1:0] reg1_value,
  input  logic [WIDTH-1:0] branch_address,
  input  logic             flag_we,
  input  logic             negative,
  input  logic             zero,
  input  logic             carry,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus1,
  output logic             taken,
  output logic [WIDTH-1:0] link_addr,
  output logic             ras_underflow
);

  flags_t           flags;
  logic             accept;
  logic             take;
  logic             is_bl;
  logic             is_ret;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] ret_target;

  assign accept   = instr_valid & ~stall;
  assign pc_plus1 = pc + WIDTH'(1);

`ifdef BRANCH_CTRL_RAS_EN
  logic             ras_empty;
  logic [WIDTH-1:0] ras_top;
  logic             ras_push;
  logic             ras_pop;

  assign ras_push = accept & is_bl;
  assign ras_pop  = accept & is_ret;

  branch_ras #(.WIDTH(WIDTH), .DEPTH(RAS_DEPTH)) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_plus1),
    .top_data  (ras_top),
    .empty     (ras_empty),
    .underflow (ras_underflow)
  );

  assign ret_target = ras_empty ? link_addr : ras_top;
`else
  assign ret_target    = link_addr;
  assign ras_underflow = 1'b0;
`endif

  // Conditions look only at the registered flags, never this cycle's ALU flags
  always_comb begin
    take   = 1'b0;
    is_bl  = 1'b0;
    is_ret = 1'b0;
    target = branch_address;
    case (branch)
      BR_REG: begin
        case (function_code)
          FN_BR:   begin take = 1'b1; target = reg1_value; end
          FN_BLTZ: take = flags.n;
          FN_BZ:   take = flags.z;
          FN_BNZ:  take = ~flags.z;
          FN_RET:  begin take = 1'b1; is_ret = 1'b1; target = ret_target; end
          default: ;
        endcase
      end
      BR_CARRY: begin
        case (function_code)
          FN_B:    take = 1'b1;
          FN_BCY:  take = flags.c;
          FN_BNCY: take = ~flags.c;
          default: ;
        endcase
      end
      BR_LINK: begin
        take  = 1'b1;
        is_bl = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= RESET_PC;
      flags     <= '0;
      link_addr <= '0;
      taken     <= 1'b0;
    end else if (!stall) begin
      if (flag_we) flags <= '{n: negative, z: zero, c: carry};
      taken <= instr_valid & take;
      if (instr_valid) begin
        pc <= take ? target : pc_plus1;
        if (is_bl) link_addr <= pc_plus1;
      end
    end else begin
      taken <= 1'b0;
    end
  end

endmodule

// File: tb/tb_branch_ctrl_unit.sv
// tb/tb_branch_ctrl_unit.sv - directed plus random checks of branch_ctrl_unit against a behavioural model
module tb_branch_ctrl_unit;

  localparam int          W   = 32;
  localparam logic [31:0] RPC = 32'h100;
  localparam int          RD  = 4;

  logic        clk = 1'b0;
  logic        rst, instr_valid, stall, flag_we, negative, zero, carry;
  logic [1:0]  branch;
  logic [5:0]  function_code;
  logic [31:0] reg1_value, branch_address;
  logic [31:0] pc, pc_plus1, link_addr;
  logic        taken, ras_underflow;

  branch_ctrl_unit #(.WIDTH(W), .RESET_PC(RPC), .RAS_DEPTH(RD)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .stall(stall),
    .branch(branch), .function_code(function_code), .reg1_value(reg1_value),
    .branch_address(branch_address), .flag_we(flag_we), .negative(negative),
    .zero(zero), .carry(carry), .pc(pc), .pc_plus1(pc_plus1), .taken(taken),
    .link_addr(link_addr), .ras_underflow(ras_underflow)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  logic [31:0] m_pc, m_link;
  logic        m_n, m_z, m_c, m_taken, m_uf;
  logic [31:0] m_ras[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Architectural rules applied to the current inputs, one instruction at a time
  task automatic model_step();
    logic [31:0] p1, tgt;
    logic        tk, uf;
    if (rst) begin
      m_pc = RPC; m_link = 0; m_n = 0; m_z = 0; m_c = 0; m_taken = 0; m_uf = 0;
      m_ras.delete();
      return;
    end
    if (stall) begin
      m_taken = 0; m_uf = 0;
      return;
    end
    p1 = m_pc + 1; tgt = branch_address; tk = 0; uf = 0;
    if (instr_valid) begin
      if (branch == 2'b01) begin
        if (function_code == 0)      begin tk = 1; tgt = reg1_value; end
        else if (function_code == 1) tk = m_n;
        else if (function_code == 2) tk = m_z;
        else if (function_code == 3) tk = !m_z;
        else if (function_code == 4) begin
          tk = 1;
`ifdef BRANCH_CTRL_RAS_EN
          if (m_ras.size() > 0) tgt = m_ras.pop_back();
          else begin tgt = m_link; uf = 1; end
`else
          tgt = m_link;
`endif
        end
      end else if (branch == 2'b10) begin
        if (function_code == 0)      tk = 1;
        else if (function_code == 1) tk = m_c;
        else if (function_code == 2) tk = !m_c;
      end else if (branch == 2'b11) begin
        tk = 1;
        m_link = p1;
`ifdef BRANCH_CTRL_RAS_EN
        m_ras.push_back(p1);
        if (m_ras.size() > RD) void'(m_ras.pop_front());
`endif
      end
      m_pc = tk ? tgt : p1;
    end
    m_taken = tk; m_uf = uf;
    if (flag_we) begin m_n = negative; m_z = zero; m_c = carry; end
  endtask

  task automatic drive(input logic r, input logic iv, input logic st, input logic [1:0] br,
                       input logic [5:0] fc, input logic [31:0] r1, input logic [31:0] ba,
                       input logic fwe, input logic n, input logic z, input logic c);
    rst = r; instr_valid = iv; stall = st; branch = br; function_code = fc;
    reg1_value = r1; branch_address = ba; flag_we = fwe; negative = n; zero = z; carry = c;
    model_step();
    @(posedge clk);
    #1;
    check("pc", pc, m_pc);
    check("pc_plus1", pc_plus1, m_pc + 32'd1);
    check("taken", {31'd0, taken}, {31'd0, m_taken});
    check("link_addr", link_addr, m_link);
    check("ras_underflow", {31'd0, ras_underflow}, {31'd0, m_uf});
  endtask

  initial begin
    // reset held two cycles with stall high and junk on the other inputs
    drive(1, 1, 1, 2'b10, 0, 32'h5, 32'h999, 1, 1, 1, 1);
    drive(1, 1, 1, 2'b10, 0, 32'h5, 32'h999, 1, 1, 1, 1);
    check("reset_pc", pc, 32'h100);
    check("reset_taken", {31'd0, taken}, 32'd0);
    check("reset_link", link_addr, 32'd0);

    drive(0, 1, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    check("seq1", pc, 32'h101);
    drive(0, 1, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    check("seq2", pc, 32'h102);
    drive(0, 1, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    check("seq3", pc, 32'h103);
    drive(0, 1, 1, 2'b10, 0, 0, 32'h777, 0, 0, 0, 0);
    drive(0, 1, 1, 2'b10, 0, 0, 32'h777, 0, 0, 0, 0);
    check("stall_pc", pc, 32'h103);
    check("stall_taken", {31'd0, taken}, 32'd0);

    // flags after reset are zero: bz falls through
    drive(0, 1, 0, 2'b01, 2, 0, 32'h300, 0, 0, 0, 0);
    check("reset_flags_bz", pc, 32'h104);
    drive(0, 0, 0, 2'b00, 0, 0, 0, 1, 0, 1, 0);
    drive(0, 1, 0, 2'b01, 2, 0, 32'h200, 0, 0, 0, 0);
    check("bz_taken_pc", pc, 32'h200);
    check("bz_taken", {31'd0, taken}, 32'd1);
    drive(0, 0, 0, 2'b00, 0, 0, 0, 1, 0, 0, 0);
    drive(0, 1, 0, 2'b01, 2, 0, 32'h300, 1, 0, 1, 0);
    check("bz_same_cycle_flag", pc, 32'h201);
    drive(0, 1, 0, 2'b01, 2, 0, 32'h300, 0, 0, 0, 0);
    check("bz_next_cycle_flag", pc, 32'h300);

    drive(0, 0, 0, 2'b00, 0, 0, 0, 1, 0, 0, 1);
    drive(0, 1, 0, 2'b10, 1, 0, 32'h40, 0, 0, 0, 0);
    check("bcy_c1", pc, 32'h40);
    drive(0, 1, 0, 2'b10, 2, 0, 32'h80, 0, 0, 0, 0);
    check("bncy_c1", pc, 32'h41);
    drive(0, 0, 0, 2'b00, 0, 0, 0, 1, 0, 0, 0);
    drive(0, 1, 0, 2'b10, 1, 0, 32'h60, 0, 0, 0, 0);
    check("bcy_c0", pc, 32'h42);
    drive(0, 1, 0, 2'b10, 2, 0, 32'h40, 0, 0, 0, 0);
    check("bncy_c0", pc, 32'h40);
    // taken even when the target equals pc+1
    drive(0, 1, 0, 2'b10, 0, 0, 32'h41, 0, 0, 0, 0);
    check("b_to_pc_plus1", {31'd0, taken}, 32'd1);

    drive(0, 1, 0, 2'b01, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0);
    check("pc_plus1_wrap", pc_plus1, 32'd0);
    drive(0, 1, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    check("pc_wrap", pc, 32'd0);
    drive(0, 1, 0, 2'b10, 0, 0, 32'h10, 0, 0, 0, 0);
    drive(0, 1, 0, 2'b11, 6'h2a, 0, 32'h80, 0, 0, 0, 0);
    check("bl_pc", pc, 32'h80);
    check("bl_link", link_addr, 32'h11);
    drive(0, 1, 0, 2'b01, 0, 32'h33, 0, 0, 0, 0, 0);
    check("br_pc", pc, 32'h33);

`ifdef BRANCH_CTRL_RAS_EN
    drive(0, 1, 0, 2'b01, 4, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 2'b10, 0, 0, 32'h10, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) drive(0, 1, 0, 2'b11, 0, 0, 32'h11 + i, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 0, 2'b01, 4, 0, 0, 0, 0, 0, 0);
      check("ras_pop", pc, 32'h15 - i);
    end
    drive(0, 1, 0, 2'b01, 4, 0, 0, 0, 0, 0, 0);
    check("ras_empty_target", pc, 32'h15);
    check("ras_underflow_pulse", {31'd0, ras_underflow}, 32'd1);
    drive(0, 1, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    check("ras_underflow_clear", {31'd0, ras_underflow}, 32'd0);
`else
    drive(0, 1, 0, 2'b01, 4, 0, 0, 0, 0, 0, 0);
    check("ret_link", pc, 32'h11);
    check("ret_taken", {31'd0, taken}, 32'd1);
`endif

    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0,
            2'($urandom_range(0, 3)), 6'($urandom_range(0, 5)),
            ($urandom_range(0, 1) != 0) ? $urandom : m_pc + 2,
            ($urandom_range(0, 1) != 0) ? $urandom : m_pc + 1,
            $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0,
            $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
